// File: rtl/systolic_pkg.sv
// Shared types and default geometry for the systolic weight loader.
package systolic_pkg;

  localparam int unsigned ARRAY_ROWS = 8;
  localparam int unsigned ARRAY_COLS = 8;
  localparam int unsigned WEIGHT_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } loader_state_t;

  typedef logic [WEIGHT_W-1:0] weight_t;

endpackage

// File: rtl/weight_row_buffer.sv
// Shadow register file: one row written per cycle, all rows readable at once.
module weight_row_buffer #(
  parameter int unsigned Rows = 8,
  parameter int unsigned RowW = 64,
  parameter int unsigned IdxW = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_i,
  input  logic [IdxW-1:0]      row_idx_i,
  input  logic [RowW-1:0]      row_data_i,
  output logic [Rows*RowW-1:0] rows_o
);

  logic [Rows*RowW-1:0] rows_q, rows_d;

  // Decode by comparison so a non-power-of-two Rows never writes out of range.
  always_comb begin
    rows_d = rows_q;
    for (int r = 0; r < int'(Rows); r++) begin
      if (we_i && (row_idx_i == IdxW'(r))) begin
        rows_d[r*RowW +: RowW] = row_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rows_q <= '0;
    end else begin
      rows_q <= rows_d;
    end
  end

  assign rows_o = rows_q;

endmodule

// File: rtl/systolic_weight_loader.sv
// Captures a burst of weight rows into a shadow buffer and commits it atomically
// to the active registers driving the PE grid.
module systolic_weight_loader
  import systolic_pkg::*;
#(
  parameter int unsigned ROWS = ARRAY_ROWS,
  parameter int unsigned COLS = ARRAY_COLS,
  parameter int unsigned DW   = WEIGHT_W,
  localparam int unsigned RCW = $clog2(ROWS + 1)
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     start_weights,
  input  logic                     weight_valid,
  input  logic [COLS*DW-1:0]       systolic_data,
  input  logic                     weight_clear,
  output logic                     loader_busy,
  output logic                     weights_done,
  output logic                     weights_loaded,
  output logic                     load_err,
  output logic [RCW-1:0]           row_count,
  output logic [ROWS*COLS*DW-1:0]  pe_weight
);

  localparam int unsigned RW = COLS * DW;
  localparam int unsigned IW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RCW-1:0] LastRow = RCW'(ROWS - 1);

  loader_state_t state_q, state_d;
  logic [RCW-1:0] count_q, count_d;
  logic           err_q, err_d;
  logic           loaded_q, loaded_d;
  logic           done_q, done_d;
  logic [ROWS*RW-1:0] active_q, active_d;

  logic           wr_en;
  logic [IW-1:0]  wr_idx;
  logic [ROWS*RW-1:0] shadow;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    err_d    = err_q;
    loaded_d = loaded_q;
    done_d   = 1'b0;
    active_d = active_q;
    wr_en    = 1'b0;
    wr_idx   = '0;

    if (weight_clear) begin
      state_d  = IDLE;
      count_d  = '0;
      err_d    = 1'b0;
      loaded_d = 1'b0;
      active_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_weights) begin
            state_d = LOAD;
            count_d = '0;
            err_d   = 1'b0;
            // A beat arriving with the start pulse is row 0 of the new burst.
            if (weight_valid) begin
              wr_en   = 1'b1;
              count_d = RCW'(1);
              if (ROWS == 1) state_d = COMMIT;
            end
          end else if (weight_valid) begin
            err_d = 1'b1;
          end
        end
        LOAD: begin
          if (start_weights) begin
            err_d   = 1'b1;
            count_d = '0;
            if (weight_valid) begin
              wr_en   = 1'b1;
              count_d = RCW'(1);
              if (ROWS == 1) state_d = COMMIT;
            end
          end else if (weight_valid) begin
            wr_en   = 1'b1;
            wr_idx  = IW'(count_q);
            count_d = count_q + RCW'(1);
            if (count_q == LastRow) state_d = COMMIT;
          end
        end
        COMMIT: begin
          active_d = shadow;
          loaded_d = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
          if (weight_valid) err_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      err_q    <= 1'b0;
      loaded_q <= 1'b0;
      done_q   <= 1'b0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      err_q    <= err_d;
      loaded_q <= loaded_d;
      done_q   <= done_d;
      active_q <= active_d;
    end
  end

  weight_row_buffer #(
    .Rows (ROWS),
    .RowW (RW),
    .IdxW (IW)
  ) u_shadow (
    .clk_i      (clk),
    .rst_ni     (n_rst),
    .we_i       (wr_en),
    .row_idx_i  (wr_idx),
    .row_data_i (systolic_data),
    .rows_o     (shadow)
  );

  assign loader_busy    = (state_q != IDLE);
  assign weights_done   = done_q;
  assign weights_loaded = loaded_q;
  assign load_err       = err_q;
  assign row_count      = count_q;
  assign pe_weight      = active_q;

endmodule

// File: tb/tb_systolic_weight_loader.sv
// Scoreboard bench: committed bursts are queued by the stimulus and checked on weights_done.
module tb_systolic_weight_loader;

  logic         clk;
  logic         n_rst;
  logic         start_weights;
  logic         weight_valid;
  logic [63:0]  systolic_data;
  logic         weight_clear;
  logic         loader_busy;
  logic         weights_done;
  logic         weights_loaded;
  logic         load_err;
  logic [3:0]   row_count;
  logic [511:0] pe_weight;

  int checks = 0;
  int errors = 0;
  int busy_cnt;
  logic [511:0] exp_q[$];
  logic [511:0] mon_exp;
  logic [511:0] pat_burst;
  logic [511:0] restart_burst;

  systolic_weight_loader dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .start_weights  (start_weights),
    .weight_valid   (weight_valid),
    .systolic_data  (systolic_data),
    .weight_clear   (weight_clear),
    .loader_busy    (loader_busy),
    .weights_done   (weights_done),
    .weights_loaded (weights_loaded),
    .load_err       (load_err),
    .row_count      (row_count),
    .pe_weight      (pe_weight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input int r);
    return 64'h0101_0101_0101_0101 * 64'(r + 1);
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; returns 1 time unit after the sampling edge.
  task automatic drive(input logic s, input logic v, input logic c, input logic [63:0] d);
    start_weights = s;
    weight_valid  = v;
    weight_clear  = c;
    systolic_data = d;
    @(posedge clk);
    #1;
    start_weights = 1'b0;
    weight_valid  = 1'b0;
    weight_clear  = 1'b0;
    systolic_data = '0;
  endtask

  always @(negedge clk) begin
    if (n_rst && weights_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no commit");
      end else begin
        mon_exp = exp_q.pop_front();
        chk("commit_pe_weight", pe_weight, mon_exp);
        chk("commit_loaded", {511'd0, weights_loaded}, 512'd1);
      end
    end
  end

  initial begin
    for (int r = 0; r < 8; r++) pat_burst[r*64 +: 64] = pat(r);
    restart_burst = pat_burst;
    restart_burst[63:0] = 64'hAAAA_AAAA_AAAA_AAAA;

    start_weights = 1'b0;
    weight_valid  = 1'b0;
    weight_clear  = 1'b0;
    systolic_data = '0;
    n_rst = 1'b1;
    #1 n_rst = 1'b0;
    #10;
    chk("rst_pe", pe_weight, '0);
    chk("rst_status", {505'd0, loader_busy, weights_done, weights_loaded, load_err, row_count},
        '0);
    @(negedge clk) n_rst = 1'b1;

    // Nominal burst
    drive(1, 0, 0, '0);
    chk("t1_busy_after_start", {511'd0, loader_busy}, 512'd1);
    exp_q.push_back(pat_burst);
    for (int r = 0; r < 8; r++) begin
      drive(0, 1, 0, pat(r));
      chk("t1_pe_hold", pe_weight, '0);
    end
    chk("t1_no_early_done", {511'd0, weights_done}, '0);
    chk("t1_count8", {508'd0, row_count}, 512'd8);
    drive(0, 0, 0, '0);
    chk("t1_done", {511'd0, weights_done}, 512'd1);
    chk("t1_busy_fall", {511'd0, loader_busy}, '0);
    chk("t1_pe_3_5", {504'd0, pe_weight[(3*8+5)*8 +: 8]}, 512'h04);
    chk("t1_err", {511'd0, load_err}, '0);
    chk("t1_count_hold", {508'd0, row_count}, 512'd8);
    drive(0, 0, 0, '0);
    chk("t1_done_pulse", {511'd0, weights_done}, '0);

    // Restart mid-burst
    drive(1, 0, 0, '0);
    for (int r = 0; r < 3; r++) drive(0, 1, 0, pat(r));
    drive(1, 1, 0, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("t3_err", {511'd0, load_err}, 512'd1);
    chk("t3_count1", {508'd0, row_count}, 512'd1);
    chk("t3_pe_hold", pe_weight, pat_burst);
    exp_q.push_back(restart_burst);
    for (int r = 1; r < 8; r++) begin
      drive(0, 1, 0, pat(r));
      chk("t3_no_early_done", {511'd0, weights_done}, '0);
    end
    chk("t3_count8", {508'd0, row_count}, 512'd8);
    drive(0, 0, 0, '0);
    chk("t3_done", {511'd0, weights_done}, 512'd1);
    chk("t3_err_sticky", {511'd0, load_err}, 512'd1);

    // Stalled stream: valid every other cycle
    busy_cnt = 0;
    drive(1, 0, 0, '0);
    chk("t2_err_cleared", {511'd0, load_err}, '0);
    if (loader_busy) busy_cnt++;
    exp_q.push_back(pat_burst);
    for (int r = 0; r < 8; r++) begin
      drive(0, 1, 0, pat(r));
      if (loader_busy) busy_cnt++;
      chk("t2_pe_old", pe_weight, restart_burst);
      if (r < 7) begin
        drive(0, 0, 0, '0);
        if (loader_busy) busy_cnt++;
      end
    end
    drive(0, 0, 0, '0);
    if (loader_busy) busy_cnt++;
    chk("t2_done", {511'd0, weights_done}, 512'd1);
    chk("t2_busy_cycles", 512'(busy_cnt), 512'd16);

    // Async reset mid-burst
    drive(1, 0, 0, '0);
    for (int r = 0; r < 4; r++) drive(0, 1, 0, pat(7 - r));
    #2 n_rst = 1'b0;
    #1;
    chk("t5_pe_zero", pe_weight, '0);
    chk("t5_status_zero",
        {505'd0, loader_busy, weights_done, weights_loaded, load_err, row_count}, '0);
    @(negedge clk) n_rst = 1'b1;
    drive(1, 0, 0, '0);
    exp_q.push_back(pat_burst);
    for (int r = 0; r < 8; r++) drive(0, 1, 0, pat(r));
    drive(0, 0, 0, '0);
    chk("t5_done", {511'd0, weights_done}, 512'd1);
    chk("t5_err", {511'd0, load_err}, '0);

    // Stray valid in IDLE, then clear
    drive(0, 1, 0, 64'hDEAD_BEEF_0000_0001);
    chk("t4_err", {511'd0, load_err}, 512'd1);
    chk("t4_pe_hold", pe_weight, pat_burst);
    chk("t4_idle", {511'd0, loader_busy}, '0);
    chk("t4_count_hold", {508'd0, row_count}, 512'd8);
    drive(0, 0, 1, '0);
    chk("t4_clr_pe", pe_weight, '0);
    chk("t4_clr_flags", {510'd0, weights_loaded, load_err}, '0);
    chk("t4_clr_count", {508'd0, row_count}, '0);

    // Clear priority over start and valid
    drive(0, 1, 0, 64'h1234);
    drive(1, 1, 1, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("t6_idle", {511'd0, loader_busy}, '0);
    chk("t6_count", {508'd0, row_count}, '0);
    chk("t6_err_cleared", {511'd0, load_err}, '0);
    drive(0, 0, 0, '0);
    chk("t6_still_idle", {511'd0, loader_busy}, '0);
    // Clear aborts a burst in progress
    drive(1, 0, 0, '0);
    drive(0, 1, 0, pat(0));
    drive(0, 1, 0, pat(1));
    drive(0, 1, 1, pat(2));
    chk("t6_abort_idle", {511'd0, loader_busy}, '0);
    chk("t6_abort_count", {508'd0, row_count}, '0);
    drive(0, 0, 0, '0);
    drive(0, 0, 0, '0);
    chk("t6_pe_zero", pe_weight, '0);
    chk("queue_drained", 512'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
